// File: rtl/conv_column_feeder.sv
`default_nettype none
// ============================================================================
// Module      : conv_column_feeder
// Description : Raster-order pixel-stream front end for the 3x3 systolic
//               convolution array. Two line memories hold the previous two
//               image rows; for every accepted pixel in rows 2 and up a
//               packed vertical column {row y-2, row y-1, row y} is emitted.
//               Build option CONV_FEEDER_ZERO_PAD_EN: when defined, columns
//               are also emitted for rows 0 and 1, and rows above the image
//               read as zero.
// Ports       : clk, rst (async, active-high)
//               pix_data/pix_valid/pix_sof/pix_ready : pixel input handshake
//               input_col/col_valid/col_ready        : column output handshake
//               col_x, col_eol                       : column position tags
//               frame_done                           : pulse after last column
// Revision    : 1.0 - initial release
// ============================================================================
module conv_column_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 32,
    parameter int IMG_HEIGHT = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         pix_data,
    input  logic                          pix_valid,
    input  logic                          pix_sof,
    output logic                          pix_ready,
    output logic [3*DATA_WIDTH-1:0]       input_col,
    output logic                          col_valid,
    input  logic                          col_ready,
    output logic [$clog2(IMG_WIDTH)-1:0]  col_x,
    output logic                          col_eol,
    output logic                          frame_done
);

    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);
    localparam logic [XW-1:0] c_X_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] c_Y_LAST = YW'(IMG_HEIGHT - 1);
    localparam logic [YW-1:0] c_Y_ONE  = YW'(1);

    typedef enum logic [0:0] {
        ST_FILL   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    state_t                     r_state;
    state_t                     w_state_next;
    state_t                     w_state_eff;
    logic [XW-1:0]              r_x;
    logic [XW-1:0]              w_x_next;
    logic [XW-1:0]              w_x_eff;
    logic [YW-1:0]              r_y;
    logic [YW-1:0]              w_y_next;
    logic [YW-1:0]              w_y_eff;

    logic [DATA_WIDTH-1:0]      r_line_a [IMG_WIDTH];   // row y-1
    logic [DATA_WIDTH-1:0]      r_line_b [IMG_WIDTH];   // row y-2
    logic [DATA_WIDTH-1:0]      w_line_a_rd;
    logic [DATA_WIDTH-1:0]      w_line_b_rd;

    logic [3*DATA_WIDTH-1:0]    r_col;
    logic                       r_col_valid;
    logic [XW-1:0]              r_col_x;
    logic                       r_col_eol;
    logic                       r_col_last;             // held column closes the frame
    logic                       r_frame_done;

    logic                       w_accept;
    logic                       w_col_take;
    logic                       w_emit;
    logic                       w_row_last;
    logic                       w_frame_last;
    logic [3*DATA_WIDTH-1:0]    w_col;

    // Single output register without skid: a new pixel may only enter when
    // the held column is absent or leaving this cycle.
    assign pix_ready  = !r_col_valid || col_ready;
    assign w_accept   = pix_valid && pix_ready;
    assign w_col_take = r_col_valid && col_ready;

    assign input_col  = r_col;
    assign col_valid  = r_col_valid;
    assign col_x      = r_col_x;
    assign col_eol    = r_col_eol;
    assign frame_done = r_frame_done;

    // A start-of-frame pixel is handled as position (0,0) in FILL whatever
    // the counters currently say.
    assign w_x_eff     = pix_sof ? '0 : r_x;
    assign w_y_eff     = pix_sof ? '0 : r_y;
    assign w_state_eff = pix_sof ? ST_FILL : r_state;

    assign w_row_last   = (w_x_eff == c_X_LAST);
    assign w_frame_last = w_row_last && (w_y_eff == c_Y_LAST);

    // Asynchronous reads so the column is built from the values present
    // before this pixel's write (read-before-write on the same address).
    assign w_line_a_rd = r_line_a[w_x_eff];
    assign w_line_b_rd = r_line_b[w_x_eff];

`ifdef CONV_FEEDER_ZERO_PAD_EN
    assign w_emit = w_accept;

    always_comb begin
        w_col = {w_line_b_rd, w_line_a_rd, pix_data};
        if (w_state_eff == ST_FILL) begin
            if (w_y_eff == '0) begin
                w_col = {{DATA_WIDTH{1'b0}}, {DATA_WIDTH{1'b0}}, pix_data};
            end else begin
                w_col = {{DATA_WIDTH{1'b0}}, w_line_a_rd, pix_data};
            end
        end
    end
`else
    assign w_emit = w_accept && (w_state_eff == ST_STREAM);
    assign w_col  = {w_line_b_rd, w_line_a_rd, pix_data};
`endif

    // ------------------------------------------------------------------
    // FSM and position counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_FILL;
            r_x     <= '0;
            r_y     <= '0;
        end else begin
            r_state <= w_state_next;
            r_x     <= w_x_next;
            r_y     <= w_y_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_x_next     = r_x;
        w_y_next     = r_y;
        if (w_accept) begin
            w_state_next = w_state_eff;
            if (w_row_last) begin
                w_x_next = '0;
                if (w_frame_last) begin
                    w_y_next     = '0;
                    w_state_next = ST_FILL;
                end else begin
                    w_y_next = w_y_eff + 1'b1;
                    // Completing row 1 means two full rows are buffered.
                    if (w_y_eff == c_Y_ONE) begin
                        w_state_next = ST_STREAM;
                    end
                end
            end else begin
                w_x_next = w_x_eff + 1'b1;
                w_y_next = w_y_eff;
            end
        end
    end

    // ------------------------------------------------------------------
    // Line memories: contents are don't-care after reset
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_line_b[w_x_eff] <= w_line_a_rd;
            r_line_a[w_x_eff] <= pix_data;
        end
    end

    // ------------------------------------------------------------------
    // Column output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col        <= '0;
            r_col_valid  <= 1'b0;
            r_col_x      <= '0;
            r_col_eol    <= 1'b0;
            r_col_last   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_col_take && r_col_last;
            if (w_emit) begin
                r_col       <= w_col;
                r_col_valid <= 1'b1;
                r_col_x     <= w_x_eff;
                r_col_eol   <= w_row_last;
                r_col_last  <= w_frame_last;
            end else if (w_col_take) begin
                r_col_valid <= 1'b0;
                r_col_last  <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_column_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_column_feeder
// Description : Self-checking bench for conv_column_feeder (4x4 image).
//               A frame-level model (pixel image array + queue of expected
//               columns) is compared against the DUT every cycle; directed
//               frames pin the model with hand-computed column values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_column_feeder;

    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 4;

`ifdef CONV_FEEDER_ZERO_PAD_EN
    localparam bit PAD        = 1'b1;
    localparam int COLS       = W * H;
    localparam int FULL0      = 8;     // index of first column with three real rows
    localparam int ABORT_COLS = 9;     // columns out of the 9 pixels before the sof
    localparam int HOLD_PIX   = 1;     // pixels that fit before a stalled output blocks
`else
    localparam bit PAD        = 1'b0;
    localparam int COLS       = W * (H - 2);
    localparam int FULL0      = 0;
    localparam int ABORT_COLS = 1;
    localparam int HOLD_PIX   = 9;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [DW-1:0]     pix_data;
    logic              pix_valid;
    logic              pix_sof;
    logic              pix_ready;
    logic [3*DW-1:0]   input_col;
    logic              col_valid;
    logic              col_ready;
    logic [1:0]        col_x;
    logic              col_eol;
    logic              frame_done;

    conv_column_feeder #(
        .DATA_WIDTH (DW),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_sof    (pix_sof),
        .pix_ready  (pix_ready),
        .input_col  (input_col),
        .col_valid  (col_valid),
        .col_ready  (col_ready),
        .col_x      (col_x),
        .col_eol    (col_eol),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: image rows of the current frame plus the queue
    // of columns still owed to the consumer.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [23:0] col;
        logic [1:0]  x;
        logic        eol;
        logic        last;
    } col_t;

    col_t        expq[$];
    logic [23:0] got[$];
    logic [7:0]  img [H][W];
    int          mx = 0;
    int          my = 0;
    bit          exp_fd = 1'b0;
    int          fd_seen = 0;

    task automatic model_accept(input logic [7:0] d, input bit sof);
        col_t       c;
        logic [7:0] up1;
        logic [7:0] up2;
        if (sof) begin
            mx = 0;
            my = 0;
        end
        up1 = 8'h00;
        up2 = 8'h00;
        if (my >= 1) up1 = img[my-1][mx];
        if (my >= 2) up2 = img[my-2][mx];
        img[my][mx] = d;
        if (PAD || my >= 2) begin
            c.col  = {up2, up1, d};
            c.x    = mx[1:0];
            c.eol  = (mx == W - 1);
            c.last = (mx == W - 1) && (my == H - 1);
            expq.push_back(c);
        end
        mx++;
        if (mx == W) begin
            mx = 0;
            my++;
            if (my == H) my = 0;
        end
    endtask

    always @(negedge clk) begin
        bit take;
        bit rdy;
        if (rst) begin
            chk("rst_col_valid",  col_valid,  0);
            chk("rst_input_col",  input_col,  0);
            chk("rst_col_x",      col_x,      0);
            chk("rst_col_eol",    col_eol,    0);
            chk("rst_frame_done", frame_done, 0);
            chk("rst_pix_ready",  pix_ready,  1);
            expq.delete();
            mx = 0;
            my = 0;
            exp_fd = 1'b0;
        end else begin
            chk("col_valid",  col_valid,  expq.size() != 0);
            rdy = (expq.size() == 0) || col_ready;
            chk("pix_ready",  pix_ready,  rdy);
            chk("frame_done", frame_done, exp_fd);
            if (frame_done) fd_seen++;
            take = 1'b0;
            if (col_valid && expq.size() != 0) begin
                chk("input_col", input_col, expq[0].col);
                chk("col_x",     col_x,     expq[0].x);
                chk("col_eol",   col_eol,   expq[0].eol);
                take = col_ready;
            end
            exp_fd = 1'b0;
            if (take) begin
                exp_fd = expq[0].last;
                got.push_back(input_col);
                void'(expq.pop_front());
            end
            if (pix_valid && rdy) model_accept(pix_data, pix_sof);
        end
    end

    // ------------------------------------------------------------------
    // Consumer: 0 always ready, 1 ready one cycle in three, 2 random, 3 stalled
    // ------------------------------------------------------------------
    int rmode = 0;
    int cyc   = 0;

    initial begin
        col_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0:       col_ready = 1'b1;
                1:       col_ready = (cyc % 3 == 0);
                2:       col_ready = 1'($urandom_range(0, 1));
                default: col_ready = 1'b0;
            endcase
            cyc++;
        end
    end

    // ------------------------------------------------------------------
    // Producer tasks
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input bit sof);
        int n;
        n = 0;
        pix_data  = d;
        pix_sof   = sof;
        pix_valid = 1'b1;
        @(negedge clk);
        while (!pix_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            miscompares++;
            $display("FAIL send_timeout: got pix_ready 0 for %0d cycles expected acceptance", n);
        end
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] base, input bit sof_first);
        for (int i = 0; i < W * H; i++) send(8'(base + i + 1), sof_first && i == 0);
    endtask

    task automatic drain();
        pix_valid = 1'b0;
        repeat (10) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    logic [23:0] ref1[$];

    initial begin
        pix_data  = '0;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        rst       = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Plain frame, consumer always ready.
        rmode = 0; got.delete(); fd_seen = 0;
        send_frame(8'h00, 1'b1);
        drain();
        chk("t1_count",      got.size(), COLS);
        chk("t1_first_full", got[FULL0], 24'h010509);
        chk("t1_last",       got[COLS-1], 24'h080C10);
`ifdef CONV_FEEDER_ZERO_PAD_EN
        chk("t1_pad_first", got[0], 24'h000001);
        chk("t1_pad_fifth", got[4], 24'h000105);
`endif
        chk("t1_frame_done", fd_seen, 1);
        ref1 = got;

        // Same frame with a consumer that stalls two cycles out of three.
        rmode = 1; got.delete(); fd_seen = 0;
        send_frame(8'h00, 1'b0);
        rmode = 0;
        drain();
        chk("t2_count", got.size(), COLS);
        for (int i = 0; i < COLS; i++) chk("t2_col", got[i], ref1[i]);
        chk("t2_frame_done", fd_seen, 1);

        // Two frames back to back.
        got.delete(); fd_seen = 0;
        send_frame(8'h00, 1'b1);
        send_frame(8'h10, 1'b1);
        drain();
        chk("t3_count",       got.size(), 2 * COLS);
        chk("t3_second_first", got[COLS+FULL0], 24'h111519);
        chk("t3_frame_done",  fd_seen, 2);

        // Frame aborted by a start-of-frame at y=2, x=1.
        got.delete(); fd_seen = 0;
        for (int i = 0; i < 9; i++) send(8'(i + 1), i == 0);
        send_frame(8'h40, 1'b1);
        drain();
        chk("t4_count",      got.size(), ABORT_COLS + COLS);
        chk("t4_frame_done", fd_seen, 1);

        // Reset while a column is held by a stalled consumer.
        rmode = 3;
        for (int i = 0; i < HOLD_PIX; i++) send(8'(i + 1), 1'b0);
        chk("t5_held_valid", col_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_async_valid", col_valid, 0);
        chk("t5_async_col",   input_col, 0);
        tick();
        rst = 1'b0;
        rmode = 0; got.delete(); fd_seen = 0;
        send_frame(8'h00, 1'b0);
        drain();
        chk("t5_count", got.size(), COLS);
        for (int i = 0; i < COLS; i++) chk("t5_col", got[i], ref1[i]);

        // Randomised traffic: data, gaps, back-pressure, stray sof, resets.
        rmode = 2;
        for (int f = 0; f < 12; f++) begin
            for (int i = 0; i < W * H; i++) begin
                repeat ($urandom_range(0, 2)) tick();
                if ($urandom_range(0, 59) == 0) do_reset();
                send(8'($urandom), (i == 0 && $urandom_range(0, 1) == 1) ||
                                   ($urandom_range(0, 39) == 0));
            end
        end
        rmode = 0;
        drain();
        chk("t6_queue_empty", expq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/conv_column_feeder.md
Name: conv_column_feeder

Overview:
Raster-order pixel-stream front end for the 3x3 systolic convolution array. It buffers the two previous image rows in line memories and emits one packed 3-pixel vertical column per accepted pixel, in the array's input_col format. The array's consumption side is the receiver; this block is the transmitter. Valid/ready handshake on both sides; frame/row position is tracked internally.

Parameters:
DATA_WIDTH, 8, pixel width in bits
IMG_WIDTH, 32, pixels per row (>=3)
IMG_HEIGHT, 32, rows per frame (>=3)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
pix_data  in  DATA_WIDTH  incoming pixel, raster order
pix_valid  in  1  pix_data valid
pix_sof  in  1  marks first pixel of frame; qualified by pix_valid
pix_ready  out  1  block accepts pixel this cycle
input_col  out  3*DATA_WIDTH  column: [3*DW-1 -: DW]=row y-2, [2*DW-1 -: DW]=row y-1, [DW-1 -: DW]=row y
col_valid  out  1  input_col valid
col_ready  in  1  downstream accepts column
col_x  out  $clog2(IMG_WIDTH)  x position of emitted column
col_eol  out  1  column is last of its row (x=IMG_WIDTH-1)
frame_done  out  1  one-cycle pulse after last column of frame is accepted

Behaviour:
- Reset: all counters 0, FSM=FILL, input_col=0, col_valid=0, col_x=0, col_eol=0, frame_done=0; line-memory contents don't care. pix_ready is combinational, so it is 1 while rst is asserted.
- pix_ready = !col_valid || col_ready (single output register, no skid). Pixel accepted when pix_valid && pix_ready.
- Counters x (0..IMG_WIDTH-1) and y (0..IMG_HEIGHT-1) advance on each accepted pixel; at x wrap, y increments.
- Line memories: lineA holds row y-1, lineB holds row y-2. On accept at x: read lineA[x] and lineB[x], write lineB[x]<=lineA[x] and lineA[x]<=pix_data. This is read-before-write on the same address.
- FSM FILL (y<2): pixels are written only; no column is produced. Transition to STREAM when the last pixel of row 1 is accepted.
- FSM STREAM (y>=2): each accept loads input_col={lineB[x],lineA[x],pix_data}, col_x=x, col_eol=(x==IMG_WIDTH-1), col_valid=1 on the next clock edge (latency 1 cycle).
- col_valid is held, with input_col stable, until col_ready=1; it then clears unless a new column loads in the same cycle (back-to-back throughput is 1 column/cycle).
- Last pixel of frame (x=W-1, y=H-1) accepted: counters wrap to 0, FSM returns to FILL. frame_done pulses 1 cycle in the cycle after that final column is accepted downstream.
- pix_sof on an accepted pixel forces that pixel to be treated as x=0,y=0, FSM=FILL, regardless of current counters. A pending col_valid column is still delivered; frame_done is not pulsed for the aborted frame.
- pix_sof on a pixel already at x=0,y=0 has no extra effect.
- col_ready ignored while col_valid=0. pix_valid low: no state change.
- Reset asserted mid-frame: immediate return to reset values; the next frame must start from x=0,y=0.
- Columns per frame: IMG_WIDTH*(IMG_HEIGHT-2).

Optional Feature:
Macro CONV_FEEDER_ZERO_PAD_EN.
- Defined: columns are also emitted during FILL. Rows above the image are substituted with 0: y=0 gives {0,0,pix}; y=1 gives {0,lineA[x],pix}. Columns per frame: IMG_WIDTH*IMG_HEIGHT. Line memories are still updated identically.
- Undefined: behaviour as above; no columns are emitted for y<2.

Test Plan:
- W=4,H=4, pixels p=y*4+x+1 streamed with col_ready=1 -> 8 columns; first input_col=24'h010509 at col_x=0; last =24'h080C10 with col_eol=1; frame_done pulses once.
- Same stream, col_ready toggling 1-of-3 cycles -> no column lost or duplicated; input_col stable while col_valid && !col_ready; pix_ready low during stall.
- Two frames back-to-back, second with p+16 -> second frame first column 24'h111519; FILL emits nothing for frame-2 rows 0-1.
- pix_sof asserted at frame-1 y=2,x=1 -> counters restart; next column appears only after 8 further pixels; no frame_done for aborted frame.
- rst pulsed mid-STREAM with col_valid=1 -> col_valid=0, input_col=0 immediately; subsequent full frame reproduces test 1 output.
- With CONV_FEEDER_ZERO_PAD_EN, test 1 stream -> 16 columns; first=24'h000001, fifth=24'h000105, ninth=24'h010509.
